responder_ctrl: RTL and testbench

//  Round controller for the 4-player quiz responder. Debounces host and player

---
 rtl/responder_ctrl.sv | 175 +++++++++++++++++
 tb/tb_responder_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/responder_ctrl.sv
// Round controller for a 4-player quiz responder: debounces keys,
// arbitrates the first press, drives the countdown timer and indicators.
// Ports:
//   CLK, RSTn           clock, async active-low reset
//   Key_Host_n          raw host key, low = pressed
//   Key_Player_n[3:0]   raw player keys P1..P4, low = pressed
//   TimerH/TimerL       BCD tens/units from the countdown timer
//   Timer_Start         1 = timer counts down
//   Timer_RSTn          0 = timer reloads
//   Winner[3:0]         latched player number 1..4, 0 = none
//   LED_Player[3:0]     one-hot LED of latched player
//   LED_Foul            latched player pressed before start
//   LED_TimeUp          round ended with no answer
//   Buzzer_Answer       pulse of BUZZ_CYC cycles on answer or foul
module responder_ctrl #(
  parameter int DB_CYC   = 500_000,
  parameter int DB_W     = 20,
  parameter int BUZZ_CYC = 25_000_000,
  parameter int BUZZ_W   = 25
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Key_Host_n,
  input  logic [3:0] Key_Player_n,
  input  logic [3:0] TimerH,
  input  logic [3:0] TimerL,
  output logic       Timer_Start,
  output logic       Timer_RSTn,
  output logic [3:0] Winner,
  output logic [3:0] LED_Player,
  output logic       LED_Foul,
  output logic       LED_TimeUp,
  output logic       Buzzer_Answer
);

  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CYC - 1);
  localparam logic [BUZZ_W-1:0] BUZ_LD  = BUZZ_W'(BUZZ_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LOCKED,
    S_FOUL,
    S_TIMEOUT
  } state_e;

  // bit 0 = host, bits 4:1 = P1..P4
  logic [4:0]      raw;
  logic [4:0]      s1_q;
  logic [4:0]      s2_q;
  logic [4:0]      acc_q;
  logic [4:0]      evt_q;
  logic [DB_W-1:0] cnt_q [5];

  assign raw = {Key_Player_n, Key_Host_n};

  // acc_q holds the accepted level in pressed polarity (1 = pressed)
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_q  <= '1;
      s2_q  <= '1;
      acc_q <= '0;
      evt_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      for (int i = 0; i < 5; i++) begin
        evt_q[i] <= 1'b0;
        if (~s2_q[i] == acc_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          cnt_q[i] <= '0;
          acc_q[i] <= ~s2_q[i];
          evt_q[i] <= ~s2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic [3:0] pl_evt;
  logic       any_pl;
  logic       host_evt;
  logic       t_zero;
  logic [3:0] win_d;
  logic [3:0] led_d;

  assign pl_evt   = evt_q[4:1];
  assign any_pl   = |pl_evt;
  assign host_evt = evt_q[0];
  assign t_zero   = (TimerH == 4'd0) && (TimerL == 4'd0);

  // lowest index wins simultaneous presses
  always_comb begin
    win_d = 4'd0;
    led_d = 4'd0;
    priority case (1'b1)
      pl_evt[0]: begin win_d = 4'd1; led_d = 4'b0001; end
      pl_evt[1]: begin win_d = 4'd2; led_d = 4'b0010; end
      pl_evt[2]: begin win_d = 4'd3; led_d = 4'b0100; end
      pl_evt[3]: begin win_d = 4'd4; led_d = 4'b1000; end
      default: ;
    endcase
  end

  state_e            state_q;
  logic [BUZZ_W-1:0] buz_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= S_IDLE;
      buz_q         <= '0;
      Timer_Start   <= 1'b0;
      Timer_RSTn    <= 1'b0;
      Winner        <= 4'd0;
      LED_Player    <= 4'd0;
      LED_Foul      <= 1'b0;
      LED_TimeUp    <= 1'b0;
      Buzzer_Answer <= 1'b0;
    end else begin
      if (buz_q != '0) buz_q <= buz_q - 1'b1;
      Buzzer_Answer <= (buz_q > BUZZ_W'(1));
      unique case (state_q)
        S_IDLE: begin
          if (host_evt) begin
            state_q     <= S_ARMED;
            Timer_Start <= 1'b1;
            Timer_RSTn  <= 1'b1;
          end else if (any_pl) begin
            state_q       <= S_FOUL;
            Winner        <= win_d;
            LED_Player    <= led_d;
            LED_Foul      <= 1'b1;
            buz_q         <= BUZ_LD;
            Buzzer_Answer <= 1'b1;
          end
        end
        S_ARMED: begin
          if (any_pl) begin
            state_q       <= S_LOCKED;
            Timer_Start   <= 1'b0;
            Winner        <= win_d;
            LED_Player    <= led_d;
            buz_q         <= BUZ_LD;
            Buzzer_Answer <= 1'b1;
          end else if (host_evt) begin
            state_q     <= S_IDLE;
            Timer_Start <= 1'b0;
            Timer_RSTn  <= 1'b0;
          end else if (t_zero) begin
            state_q     <= S_TIMEOUT;
            Timer_Start <= 1'b0;
            LED_TimeUp  <= 1'b1;
          end
        end
        default: begin
          if (host_evt) begin
            state_q       <= S_IDLE;
            Timer_Start   <= 1'b0;
            Timer_RSTn    <= 1'b0;
            Winner        <= 4'd0;
            LED_Player    <= 4'd0;
            LED_Foul      <= 1'b0;
            LED_TimeUp    <= 1'b0;
            buz_q         <= '0;
            Buzzer_Answer <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_responder_ctrl.sv
// Randomized scoreboard bench for responder_ctrl.
// Model predicts each output change and the cycle it appears.
module tb_responder_ctrl;

  localparam int DB  = 4;
  localparam int BZ  = 8;
  localparam int LAT = DB + 3;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_LOCK = 2;
  localparam int P_FOUL = 3;
  localparam int P_TO   = 4;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       Key_Host_n = 1'b1;
  logic [3:0] Key_Player_n = 4'hf;
  logic [3:0] TimerH = 4'd3;
  logic [3:0] TimerL = 4'd0;
  logic       Timer_Start;
  logic       Timer_RSTn;
  logic [3:0] Winner;
  logic [3:0] LED_Player;
  logic       LED_Foul;
  logic       LED_TimeUp;
  logic       Buzzer_Answer;

  responder_ctrl #(
    .DB_CYC(DB), .DB_W(4), .BUZZ_CYC(BZ), .BUZZ_W(5)
  ) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Key_Host_n(Key_Host_n), .Key_Player_n(Key_Player_n),
    .TimerH(TimerH), .TimerL(TimerL),
    .Timer_Start(Timer_Start), .Timer_RSTn(Timer_RSTn),
    .Winner(Winner), .LED_Player(LED_Player),
    .LED_Foul(LED_Foul), .LED_TimeUp(LED_TimeUp),
    .Buzzer_Answer(Buzzer_Answer)
  );

  always #5 CLK = ~CLK;

  logic [12:0] vec;
  assign vec = {Timer_Start, Timer_RSTn, Winner, LED_Player,
                LED_Foul, LED_TimeUp, Buzzer_Answer};

  typedef struct {
    int          t;
    logic [12:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   phase = P_IDLE;
  int   win = 0;
  logic started = 1'b0;

  initial forever @(posedge CLK) cyc++;

  function automatic logic [12:0] model_vec(input logic buz);
    logic [3:0] w;
    logic [3:0] led;
    w   = 4'(win);
    led = (win == 0) ? 4'd0 : 4'(1 << (win - 1));
    return {phase == P_ARM,
            phase == P_ARM || phase == P_LOCK || phase == P_TO,
            w, led, phase == P_FOUL, phase == P_TO, buz};
  endfunction

  function automatic int lowest(input logic [3:0] pm);
    for (int i = 0; i < 4; i++) if (pm[i]) return i + 1;
    return 0;
  endfunction

  task automatic push(input int t, input logic buz);
    exp_t e;
    e.t = t;
    e.v = model_vec(buz);
    q.push_back(e);
  endtask

  task automatic latch(input int t, input int ph, input logic [3:0] pm);
    phase = ph;
    win   = lowest(pm);
    push(t, 1'b1);
    push(t + BZ, 1'b0);
  endtask

  task automatic apply_evt(input int t, input logic h, input logic [3:0] pm);
    case (phase)
      P_IDLE: begin
        if (h) begin
          phase = P_ARM;
          push(t, 1'b0);
        end else if (pm != 0) begin
          latch(t, P_FOUL, pm);
        end
      end
      P_ARM: begin
        if (pm != 0) begin
          latch(t, P_LOCK, pm);
        end else if (h) begin
          phase = P_IDLE;
          win = 0;
          push(t, 1'b0);
        end
      end
      default: begin
        if (h) begin
          phase = P_IDLE;
          win = 0;
          push(t, 1'b0);
        end
      end
    endcase
  endtask

  task automatic apply_zero(input int t);
    if (phase == P_ARM) begin
      phase = P_TO;
      push(t, 1'b0);
    end
  endtask

  // press keys for 'hold' cycles; optionally show 00 on the timer for
  // one cycle starting 'zoff' cycles in; always spans 30 cycles
  task automatic act(input logic h, input logic [3:0] pm,
                     input int hold, input int zoff);
    int  c0;
    int  te;
    int  tz;
    bit  he;
    bit  hz;
    c0 = cyc;
    he = (hold >= DB) && (h || pm != 0);
    hz = (zoff >= 0);
    te = c0 + LAT;
    tz = c0 + zoff + 1;
    if (hz && (!he || tz < te)) apply_zero(tz);
    if (he) apply_evt(te, h, pm);
    if (hz && he && tz > te) apply_zero(tz);
    for (int k = 0; k < 30; k++) begin
      if (k == 0) begin
        Key_Host_n   = ~h;
        Key_Player_n = ~pm;
      end
      if (k == hold) begin
        Key_Host_n   = 1'b1;
        Key_Player_n = 4'hf;
      end
      if (k == zoff) begin
        TimerH = 4'd0;
        TimerL = 4'd0;
      end
      if (zoff >= 0 && k == zoff + 1) begin
        TimerH = 4'($urandom_range(1, 3));
        TimerL = 4'($urandom_range(0, 9));
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    exp_t        e;
    logic [12:0] prev;
    prev = '0;
    forever begin
      @(negedge CLK);
      if (started && vec !== prev) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_change cyc %0d: got %b, required %b",
                   cyc, vec, prev);
        end else begin
          e = q.pop_front();
          if (e.t == cyc && e.v === vec) passes++;
          else $display("FAIL output cyc %0d: got %b, required %b at cyc %0d",
                        cyc, vec, e.v, e.t);
        end
      end
      prev = vec;
    end
  end

  task automatic direct(input string name, input logic [12:0] req);
    checks++;
    if (vec === req) passes++;
    else $display("FAIL %s: got %b, required %b", name, vec, req);
  endtask

  initial begin
    int          c0;
    int          r;
    logic [3:0]  pm;
    exp_t        dummy;
    repeat (3) @(negedge CLK);
    direct("reset_state", 13'd0);
    RSTn = 1'b1;
    started = 1'b1;
    repeat (5) @(negedge CLK);

    act(1'b1, 4'b0000, 10, -1);
    act(1'b0, 4'b0100, 6, -1);
    act(1'b0, 4'b0001, 6, -1);
    act(1'b1, 4'b0000, 6, -1);
    act(1'b0, 4'b0010, 6, -1);
    act(1'b1, 4'b0000, 6, -1);
    act(1'b1, 4'b0000, 6, -1);
    act(1'b0, 4'b1010, 6, -1);
    act(1'b1, 4'b0000, 6, -1);
    act(1'b1, 4'b0000, 6, -1);
    act(1'b0, 4'b1000, 6, LAT - 1);
    act(1'b1, 4'b0000, 6, -1);
    act(1'b1, 4'b0000, 6, -1);
    act(1'b0, 4'b0000, 0, 0);
    act(1'b1, 4'b0000, 6, -1);
    act(1'b0, 4'b0001, 3, -1);
    act(1'b1, 4'b0000, 6, -1);

    // P2 locks, then reset lands while the buzzer is sounding
    c0 = cyc;
    apply_evt(c0 + LAT, 1'b0, 4'b0010);
    Key_Player_n = 4'b1101;
    repeat (6) @(negedge CLK);
    Key_Player_n = 4'hf;
    repeat (LAT + 3 - 6) @(negedge CLK);
    #2;
    RSTn = 1'b0;
    while (q.size() > 0 && q[$].t > cyc) dummy = q.pop_back();
    phase = P_IDLE;
    win = 0;
    push(cyc + 1, 1'b0);
    #1;
    direct("reset_mid_buzz", 13'd0);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (10) @(negedge CLK);

    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 5);
      pm = 4'($urandom_range(1, 15));
      case (r)
        0: act(1'b1, 4'b0000, $urandom_range(DB, 10), -1);
        1: act(1'b0, pm, $urandom_range(DB, 10), -1);
        2: act(1'b0, 4'(1 << $urandom_range(0, 3)),
               $urandom_range(1, DB - 1), -1);
        3: act(1'b0, 4'b0000, 0, 0);
        4: act(1'b0, pm, 6, (phase == P_ARM) ? LAT - 1 : -1);
        default: act(1'b1, (phase == P_IDLE) ? pm : 4'b0000, 6, -1);
      endcase
    end

    repeat (20) @(negedge CLK);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL pending: got %0d unseen changes (first at cyc %0d), required 0",
                  q.size(), q[0].t);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
